// File: rtl/host_serdes.sv
// Byte-serial host for a far-end calculator: streams operands A and B out a byte lane,
// holds the calculation window, then collects the result bytes back into res_z.
module host_serdes #(
  parameter int WIDTH       = 24,
  parameter int CALC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_z,
  output logic             dut_reset,
  output logic [7:0]       to_dut,
  input  logic [7:0]       from_dut,
  output logic             start_calc,
  output logic             output_result
);

  localparam int NBYTES  = WIDTH / 8;
  localparam int CNT_MAX = (NBYTES > CALC_CYCLES) ? NBYTES : CALC_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    CALC   = 3'd3,
    READ   = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic             last_byte_s;
  logic             last_calc_s;
  logic [WIDTH+7:0] shifted_s;

  // Byte idx of x counted from the most significant byte; out-of-range idx yields 0.
  function automatic logic [7:0] byte_of(input logic [WIDTH-1:0] x, input int idx);
    logic [WIDTH-1:0] sh;
    sh = x >> ((NBYTES - 1 - idx) * 8);
    return sh[7:0];
  endfunction

  assign last_byte_s = (cnt_r == CW'(NBYTES - 1));
  assign last_calc_s = (cnt_r == CW'(CALC_CYCLES - 1));
  assign shifted_s   = {res_z, from_dut};

  // Transaction sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      cnt_r         <= '0;
      a_r           <= '0;
      b_r           <= '0;
      op_ready      <= 1'b1;
      res_valid     <= 1'b0;
      res_z         <= '0;
      dut_reset     <= 1'b0;
      to_dut        <= 8'h00;
      start_calc    <= 1'b0;
      output_result <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (op_valid) begin
            a_r       <= op_a;
            b_r       <= op_b;
            cnt_r     <= '0;
            to_dut    <= byte_of(op_a, 0);
            dut_reset <= 1'b1;
            op_ready  <= 1'b0;
            state_r   <= SEND_A;
          end
        end
        SEND_A: begin
          if (last_byte_s) begin
            cnt_r   <= '0;
            to_dut  <= byte_of(b_r, 0);
            state_r <= SEND_B;
          end else begin
            cnt_r  <= cnt_r + CW'(1);
            to_dut <= byte_of(a_r, int'(cnt_r) + 1);
          end
        end
        SEND_B: begin
          if (last_byte_s) begin
            cnt_r      <= '0;
            to_dut     <= 8'h00;
            start_calc <= 1'b1;
            state_r    <= CALC;
          end else begin
            cnt_r  <= cnt_r + CW'(1);
            to_dut <= byte_of(b_r, int'(cnt_r) + 1);
          end
        end
        CALC: begin
          if (last_calc_s) begin
            cnt_r         <= '0;
            output_result <= 1'b1;
            state_r       <= READ;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        READ: begin
          // The far end answers one cycle late, so the first READ cycle has nothing to take.
          if (cnt_r != '0) begin
            res_z <= shifted_s[WIDTH-1:0];
          end
          if (last_byte_s) begin
            cnt_r         <= '0;
            output_result <= 1'b0;
            state_r       <= DRAIN;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DRAIN: begin
          res_z      <= shifted_s[WIDTH-1:0];
          start_calc <= 1'b0;
          res_valid  <= 1'b1;
          state_r    <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            dut_reset <= 1'b0;
            op_ready  <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r       <= IDLE;
          cnt_r         <= '0;
          op_ready      <= 1'b1;
          res_valid     <= 1'b0;
          dut_reset     <= 1'b0;
          to_dut        <= 8'h00;
          start_calc    <= 1'b0;
          output_result <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_serdes.sv
// Directed bench for host_serdes: default 24-bit instance plus an 8-bit / CALC_CYCLES=1 instance,
// each paired with a small far-end model that returns a fixed result byte stream.
module tb_host_serdes;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        op_valid, op_ready, res_valid, res_ready, dut_reset, start_calc, output_result;
  logic [23:0] op_a, op_b, res_z;
  logic [7:0]  to_dut, from_dut;

  logic        op_valid8, op_ready8, res_valid8, res_ready8, dut_reset8, start_calc8, output_result8;
  logic [7:0]  op_a8, op_b8, res_z8, to_dut8, from_dut8;

  logic [23:0] far_z;
  logic [7:0]  far_z8;
  int          fidx;

  int checks = 0;
  int errors = 0;
  int n;
  int orc;

  host_serdes dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .dut_reset(dut_reset), .to_dut(to_dut), .from_dut(from_dut),
    .start_calc(start_calc), .output_result(output_result)
  );

  host_serdes #(.WIDTH(8), .CALC_CYCLES(1)) dut8 (
    .clk(clk), .reset(reset), .op_valid(op_valid8), .op_ready(op_ready8),
    .op_a(op_a8), .op_b(op_b8), .res_valid(res_valid8), .res_ready(res_ready8),
    .res_z(res_z8), .dut_reset(dut_reset8), .to_dut(to_dut8), .from_dut(from_dut8),
    .start_calc(start_calc8), .output_result(output_result8)
  );

  // Far end of the 24-bit link: one registered result byte per output_result cycle, MSB first.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fidx     <= 0;
      from_dut <= 8'h00;
    end else if (!dut_reset) begin
      fidx <= 0;
    end else if (output_result) begin
      from_dut <= 8'((far_z >> ((2 - fidx) * 8)) & 24'h0000FF);
      fidx     <= fidx + 1;
    end
  end

  // Far end of the 8-bit link.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      from_dut8 <= 8'h00;
    end else if (output_result8) begin
      from_dut8 <= far_z8;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"}, 64'(op_ready), 64'd1);
    check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
    check({tag, "_res_z"}, 64'(res_z), 64'd0);
    check({tag, "_to_dut"}, 64'(to_dut), 64'd0);
    check({tag, "_dut_reset"}, 64'(dut_reset), 64'd0);
    check({tag, "_start_calc"}, 64'(start_calc), 64'd0);
    check({tag, "_output_result"}, 64'(output_result), 64'd0);
  endtask

  // Waits (bounded) for res_valid, counting edges since accept and output_result cycles.
  task automatic wait_res(input int start, output int edges, output int orcnt);
    edges = start;
    orcnt = 0;
    while (!res_valid && edges < 60) begin
      @(negedge clk);
      edges++;
      if (output_result) orcnt++;
    end
  endtask

  logic [7:0] exp_bytes [6];

  initial begin
    exp_bytes = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    reset = 1'b0;
    op_valid = 1'b0; op_a = 24'h0; op_b = 24'h0; res_ready = 1'b0;
    op_valid8 = 1'b0; op_a8 = 8'h0; op_b8 = 8'h0; res_ready8 = 1'b0;
    far_z = 24'hC0FFEE; far_z8 = 8'hD7;

    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_op_ready", 64'(op_ready), 64'd1);

    // Basic transaction
    op_valid = 1'b1; op_a = 24'h123456; op_b = 24'hABCDEF;
    @(negedge clk);
    op_valid = 1'b0;
    check("byte0", 64'(to_dut), 64'(exp_bytes[0]));
    check("send_dut_reset", 64'(dut_reset), 64'd1);
    check("send_op_ready", 64'(op_ready), 64'd0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("byte%0d", i), 64'(to_dut), 64'(exp_bytes[i]));
    end
    @(negedge clk);
    check("calc_start", 64'(start_calc), 64'd1);
    check("calc_outres", 64'(output_result), 64'd0);
    check("calc_to_dut", 64'(to_dut), 64'd0);
    wait_res(6, n, orc);
    check("latency", 64'(n), 64'd12);
    check("outres_cycles", 64'(orc), 64'd3);
    check("res_z", 64'(res_z), 64'hC0FFEE);
    check("done_start", 64'(start_calc), 64'd0);

    // Backpressure with op_valid offered while DONE
    op_valid = 1'b1; op_a = 24'h111111; op_b = 24'h222222;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_z", 64'(res_z), 64'hC0FFEE);
      check("bp_op_ready", 64'(op_ready), 64'd0);
    end
    op_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("hs_res_valid", 64'(res_valid), 64'd0);
    check("hs_op_ready", 64'(op_ready), 64'd1);
    check("hs_res_z_hold", 64'(res_z), 64'hC0FFEE);
    check("hs_dut_reset", 64'(dut_reset), 64'd0);

    // Back-to-back
    far_z = 24'h123ABC; op_a = 24'h0F1E2D; op_b = 24'h3C4B5A; op_valid = 1'b1;
    @(negedge clk);
    check("b2b1_byte0", 64'(to_dut), 64'h0F);
    wait_res(0, n, orc);
    check("b2b1_latency", 64'(n), 64'd12);
    check("b2b1_res_z", 64'(res_z), 64'h123ABC);
    far_z = 24'h5A6B7C; op_a = 24'hE1D2C3;
    @(negedge clk);
    check("b2b_idle_ready", 64'(op_ready), 64'd1);
    check("b2b_idle_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    op_valid = 1'b0;
    check("b2b2_byte0", 64'(to_dut), 64'hE1);
    check("b2b2_op_ready", 64'(op_ready), 64'd0);
    wait_res(0, n, orc);
    check("b2b2_latency", 64'(n), 64'd12);
    check("b2b2_res_z", 64'(res_z), 64'h5A6B7C);
    @(negedge clk);
    check("b2b_back_idle", 64'(op_ready), 64'd1);

    // Reset pulsed during SEND_B
    far_z = 24'h8899AA; op_a = 24'h13579B; op_b = 24'h2468AC; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_sendb", 64'(to_dut), 64'h24);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midop");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
    check("post_byte0", 64'(to_dut), 64'h13);
    wait_res(0, n, orc);
    check("post_latency", 64'(n), 64'd12);
    check("post_res_z", 64'(res_z), 64'h8899AA);

    // WIDTH=8, CALC_CYCLES=1 instance
    res_ready8 = 1'b1; op_a8 = 8'h5C; op_b8 = 8'h3E; op_valid8 = 1'b1;
    @(negedge clk);
    op_valid8 = 1'b0;
    check("w8_byte_a", 64'(to_dut8), 64'h5C);
    check("w8_dut_reset", 64'(dut_reset8), 64'd1);
    @(negedge clk);
    check("w8_byte_b", 64'(to_dut8), 64'h3E);
    n = 1;
    orc = 0;
    while (!res_valid8 && n < 40) begin
      @(negedge clk);
      n++;
      if (output_result8) orc++;
    end
    check("w8_latency", 64'(n), 64'd5);
    check("w8_outres_cycles", 64'(orc), 64'd1);
    check("w8_res_z", 64'(res_z8), 64'hD7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
